// File: rtl/ahb_sram_slave_pkg.sv
// Shared definitions for the coefficient-bank AHB-lite SRAM slaves:
// FSM state encoding, AHB transfer constants and wait-state limits.
package ahb_sram_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_RD_DATA  = 3'd4,
        ST_ERR1     = 3'd5,
        ST_ERR2     = 3'd6
    } state_e;

    // Only full 128-bit beats are legal on this port.
    localparam logic [3:0] HSIZE_128 = 4'b0100;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Extra read wait states are held in a 3-bit down-counter.
    localparam int WAIT_STATES_MAX = 7;
    localparam int WCNT_W          = 3;

endpackage

// File: rtl/ahb_slv_decode.sv
// Address-phase decode shared by the bank slaves: checks that a transfer is
// a 16-byte aligned, 128-bit beat inside the bank and extracts the word index.
module ahb_slv_decode
    import ahb_sram_slave_pkg::*;
#(
    parameter int AWIDTH = 13
) (
    input  logic [31:0]       haddr_i,
    input  logic [3:0]        hsize_i,
    output logic              legal_o,
    output logic [AWIDTH-1:0] idx_o
);

    // Legality and word index are pure functions of the address phase.
    always_comb begin
        idx_o   = haddr_i[AWIDTH+3:4];
        legal_o = (haddr_i[3:0] == 4'h0) &&
                  (hsize_i == HSIZE_128) &&
                  (haddr_i[31:AWIDTH+4] == '0);
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-lite slave mapping 128-bit beats onto one single-port synchronous SRAM.
// The SRAM is touched only in data phases, so a write followed directly by a
// read never competes for the macro. Reads take 1 + WAIT_STATES wait cycles.
// Build option: define AHB_SRAM_ERR_EN to answer illegal transfers with a
// two-cycle ERROR response; otherwise they complete OKAY with no SRAM access
// (writes dropped, reads return zero).
//
// Handshake: a transfer is accepted when hsel & htrans[1] & hready are all
// high at a rising edge while this slave is able to start a new data phase;
// the data phase completes on the first edge where hreadyout is high.
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter int DWIDTH      = 128,
    parameter int AWIDTH      = 13,
    parameter int WAIT_STATES = 0
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              hsel,
    input  logic [31:0]       haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [3:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [DWIDTH-1:0] hwdata,
    input  logic              hready,
    output logic [DWIDTH-1:0] hrdata,
    output logic              hreadyout,
    output logic              hresp,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic [2:0]        dbg_state_o
);

    // Counter reload for RD_WAIT; WAIT_STATES above the maximum is clamped.
    localparam int WS_EFF  = (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX : WAIT_STATES;
    localparam int WS_LD_I = (WS_EFF > 0) ? (WS_EFF - 1) : 0;
    localparam logic [WCNT_W-1:0] WS_LOAD = WCNT_W'(WS_LD_I);

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   cnt_q, cnt_d;
    logic [AWIDTH-1:0]   idx_q;
    logic [DWIDTH-1:0]   cap_q;
    logic [DWIDTH-1:0]   hold_q;
    logic                fresh_q;

    logic                dec_legal;
    logic [AWIDTH-1:0]   dec_idx;
    logic                can_accept;
    logic                accept;
    state_e              acc_next;
    logic [DWIDTH-1:0]   rd_word;

    // hburst and htrans[0] carry no meaning for single-beat handling.
    logic unused_bus;
    assign unused_bus = ^{hburst, htrans[0]};

    ahb_slv_decode #(.AWIDTH(AWIDTH)) u_decode (
        .haddr_i (haddr),
        .hsize_i (hsize),
        .legal_o (dec_legal),
        .idx_o   (dec_idx)
    );

    assign dbg_state_o = state_q;
    assign rd_word     = (WAIT_STATES == 0) ? mem_rdata : cap_q;

    // States with hreadyout high may start a new data phase.
    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_WR) ||
                        (state_q == ST_RD_DATA) || (state_q == ST_ERR2);
    assign accept     = hsel && htrans[1] && hready && can_accept;

    // State and wait counter register.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: data-phase sequencing plus the next accepted transfer.
    always_comb begin
        if (!accept) begin
            acc_next = ST_IDLE;
        end else if (!dec_legal) begin
`ifdef AHB_SRAM_ERR_EN
            acc_next = ST_ERR1;
`else
            acc_next = ST_IDLE;
`endif
        end else if (hwrite) begin
            acc_next = ST_WR;
        end else begin
            acc_next = ST_RD_ISSUE;
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_WR, ST_RD_DATA: state_d = acc_next;
            ST_RD_ISSUE: begin
                if (WS_EFF > 0) begin
                    state_d = ST_RD_WAIT;
                    cnt_d   = WS_LOAD;
                end else begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RD_DATA;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
`ifdef AHB_SRAM_ERR_EN
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = acc_next;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: SRAM strobes and bus response per state; quiet while in reset.
    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        hrdata    = '0;
        if (!hreset) begin
            hrdata = hold_q;
            case (state_q)
                ST_WR: begin
                    mem_ce    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = idx_q;
                    mem_wdata = hwdata;
                end
                ST_RD_ISSUE: begin
                    hreadyout = 1'b0;
                    mem_ce    = 1'b1;
                    mem_addr  = idx_q;
                end
                ST_RD_WAIT: hreadyout = 1'b0;
                ST_RD_DATA: hrdata = rd_word;
`ifdef AHB_SRAM_ERR_EN
                ST_ERR1: begin
                    hresp     = 1'b1;
                    hreadyout = 1'b0;
                end
                ST_ERR2: hresp = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    // Datapath: latch word index, capture SRAM data, hold last read value.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            idx_q   <= '0;
            cap_q   <= '0;
            hold_q  <= '0;
            fresh_q <= 1'b0;
        end else begin
            fresh_q <= (state_q == ST_RD_ISSUE);
            if (fresh_q) begin
                cap_q <= mem_rdata;
            end
            if (accept) begin
                idx_q <= dec_idx;
            end
            if (state_q == ST_RD_DATA) begin
                hold_q <= rd_word;
            end
`ifndef AHB_SRAM_ERR_EN
            // An illegal read returns zero in its (zero-wait) data phase.
            if (accept && !dec_legal && !hwrite) begin
                hold_q <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: pipelined AHB master, SRAM model and
// a transaction-level reference memory predicting every bus cycle.
module tb_ahb_sram_slave;

    localparam int DW = 128;
    localparam int AW = 13;
    localparam int WS = 3;
`ifdef AHB_SRAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic          hclk   = 1'b0;
    logic          hreset = 1'b1;
    logic          hsel   = 1'b0;
    logic [31:0]   haddr  = '0;
    logic [1:0]    htrans = 2'b00;
    logic          hwrite = 1'b0;
    logic [3:0]    hsize  = 4'b0100;
    logic [2:0]    hburst = 3'b000;
    logic [DW-1:0] hwdata = '0;
    logic          hready;
    logic [DW-1:0] hrdata;
    logic          hreadyout;
    logic          hresp;
    logic          mem_ce;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [2:0]    dbg_state;

    always #5 hclk = ~hclk;

    // Single slave on the bus: bus-level ready is this slave's ready.
    assign hready = hreadyout;

    ahb_sram_slave #(.DWIDTH(DW), .AWIDTH(AW), .WAIT_STATES(WS)) dut (
        .hclk        (hclk),
        .hreset      (hreset),
        .hsel        (hsel),
        .haddr       (haddr),
        .htrans      (htrans),
        .hwrite      (hwrite),
        .hsize       (hsize),
        .hburst      (hburst),
        .hwdata      (hwdata),
        .hready      (hready),
        .hrdata      (hrdata),
        .hreadyout   (hreadyout),
        .hresp       (hresp),
        .mem_ce      (mem_ce),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .dbg_state_o (dbg_state)
    );

    // Synchronous single-port SRAM: read data one cycle after ce & !we.
    logic [DW-1:0] sram [0:(1<<AW)-1] = '{default: '0};
    always @(posedge hclk) begin
        if (mem_ce && mem_we) sram[mem_addr] <= mem_wdata;
        if (mem_ce && !mem_we) mem_rdata <= sram[mem_addr];
    end

    // ---------------- reference model ----------------
    typedef struct {
        bit          idle;
        int          mode;
        bit          wr;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [3:0]  size;
        logic [DW-1:0] wdata;
    } txn_t;

    txn_t          txq[$];
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] last_rdata = '0;
    int            n_cmp = 0;
    int            n_mis = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit legal_of(input txn_t t);
        return (t.addr % 16 == 0) && (t.size == 4'd4) && (t.addr < 32'h0002_0000);
    endfunction

    function automatic int waits_of(input txn_t t);
        if (t.idle) return 0;
        if (!legal_of(t)) return ERR_EN ? 1 : 0;
        return t.wr ? 0 : 1 + WS;
    endfunction

    function automatic bit err_of(input txn_t t);
        return ERR_EN && !t.idle && !legal_of(t);
    endfunction

    function automatic logic [DW-1:0] mem_of(input logic [31:0] a);
        int k;
        k = int'(a / 16);
        return ref_mem.exists(k) ? ref_mem[k] : '0;
    endfunction

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic txn_t mk(input bit wr, input logic [31:0] addr, input logic [DW-1:0] d);
        txn_t t;
        t.idle  = 1'b0;
        t.mode  = 0;
        t.wr    = wr;
        t.trans = 2'b10;
        t.addr  = addr;
        t.size  = 4'b0100;
        t.wdata = d;
        return t;
    endfunction

    function automatic txn_t mk_idle(input int mode);
        txn_t t;
        t      = mk(1'($urandom_range(0, 1)), 32'h300, rnd_word());
        t.idle = 1'b1;
        t.mode = mode;
        return t;
    endfunction

    function automatic txn_t rnd_txn();
        txn_t t;
        int   r;
        r = $urandom_range(0, 15);
        t = mk(1'($urandom_range(0, 1)), 32'h300 + 32'($urandom_range(0, 15)) * 16, rnd_word());
        t.trans = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
        if (r < 3) t = mk_idle(r);
        else if (r == 3) t.addr = t.addr + 32'($urandom_range(1, 15));
        else if (r == 4) t.size = 4'($urandom_range(0, 3));
        else if (r == 5) t.addr = t.addr | (32'h1 << $urandom_range(17, 31));
        return t;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input bit ap_v, input txn_t ap, input bit dp_v, input txn_t dp);
        hburst = 3'($urandom_range(0, 7));
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 4'b0100;
        haddr  = $urandom();
        if (ap_v) begin
            hwrite = ap.wr;
            haddr  = ap.addr;
            hsize  = ap.size;
            if (!ap.idle) begin
                hsel   = 1'b1;
                htrans = ap.trans;
            end else if (ap.mode == 0) begin
                hsel   = 1'b0;
                htrans = 2'b10;
            end else if (ap.mode == 1) begin
                hsel   = 1'b1;
                htrans = 2'b00;
            end else begin
                hsel   = 1'b1;
                htrans = 2'b01;
            end
        end
        hwdata = (dp_v && dp.wr && !dp.idle) ? dp.wdata : rnd_word();
    endtask

    // Runs the queued transfers as a pipelined master; entered at posedge+1.
    task automatic run_seq(input string name);
        txn_t          ap, dp;
        bit            ap_v, dp_v, exp_rdy, rd_done, exp_ce;
        int            waits, cycles, exp_cycles;
        logic [DW-1:0] exp_rd;
        ap = mk_idle(0);
        dp = mk_idle(0);
        ap_v = 1'b0;
        dp_v = 1'b0;
        waits = 0;
        cycles = 0;
        exp_cycles = 1;
        foreach (txq[i]) exp_cycles += 1 + waits_of(txq[i]);
        if (txq.size() > 0) begin
            ap = txq.pop_front();
            ap_v = 1'b1;
        end
        while ((ap_v || dp_v) && cycles < 20000) begin
            drive(ap_v, ap, dp_v, dp);
            @(negedge hclk);
            cycles++;
            exp_rdy = !dp_v || (waits >= waits_of(dp));
            rd_done = dp_v && exp_rdy && !dp.idle && !dp.wr;
            exp_rd  = last_rdata;
            if (rd_done) exp_rd = legal_of(dp) ? mem_of(dp.addr) : (ERR_EN ? last_rdata : '0);
            exp_ce  = dp_v && !dp.idle && legal_of(dp) && (waits == 0);
            check_eq({name, ":hreadyout"}, hreadyout, exp_rdy);
            check_eq({name, ":hresp"}, hresp, dp_v && err_of(dp));
            check_eq({name, ":hrdata"}, hrdata, exp_rd);
            check_eq({name, ":mem_ce"}, mem_ce, exp_ce);
            check_eq({name, ":mem_we"}, mem_we, exp_ce && dp.wr);
            if (exp_ce) check_eq({name, ":mem_addr"}, mem_addr, dp.addr / 16);
            if (exp_ce && dp.wr) check_eq({name, ":mem_wdata"}, mem_wdata, dp.wdata);
            if (hreadyout) begin
                if (rd_done) last_rdata = exp_rd;
                if (dp_v && !dp.idle && dp.wr && legal_of(dp)) ref_mem[int'(dp.addr / 16)] = dp.wdata;
                dp    = ap;
                dp_v  = ap_v;
                waits = 0;
                ap_v  = 1'b0;
                if (txq.size() > 0) begin
                    ap = txq.pop_front();
                    ap_v = 1'b1;
                end
            end else begin
                waits++;
            end
            @(posedge hclk);
            #1;
        end
        check_eq({name, ":done"}, ap_v || dp_v, 1'b0);
        check_eq({name, ":cycles"}, cycles, exp_cycles);
        drive(1'b0, ap, 1'b0, dp);
    endtask

    // Reset asserted while a read sits in its SRAM issue cycle.
    task automatic reset_during_read();
        txn_t t;
        t = mk(1'b0, 32'h10, '0);
        drive(1'b1, t, 1'b0, t);
        @(negedge hclk);
        check_eq("rst_rd:accept", hreadyout, 1'b1);
        @(posedge hclk); #1;
        drive(1'b0, t, 1'b0, t);
        hreset = 1'b1;
        @(posedge hclk); #1;
        hreset = 1'b0;
        @(negedge hclk);
        check_eq("rst_rd:hreadyout", hreadyout, 1'b1);
        check_eq("rst_rd:hresp", hresp, 1'b0);
        check_eq("rst_rd:hrdata", hrdata, '0);
        last_rdata = '0;
        @(posedge hclk); #1;
    endtask

    // Reset asserted in a write data phase: the write must not reach the SRAM.
    task automatic reset_during_write();
        txn_t t;
        t = mk(1'b1, 32'h200, rnd_word() | 128'h1);
        drive(1'b1, t, 1'b0, t);
        @(negedge hclk);
        check_eq("rst_wr:accept", hreadyout, 1'b1);
        @(posedge hclk); #1;
        drive(1'b0, t, 1'b1, t);
        hreset = 1'b1;
        @(negedge hclk);
        check_eq("rst_wr:mem_we", mem_we, 1'b0);
        @(posedge hclk); #1;
        hreset = 1'b0;
        drive(1'b0, t, 1'b0, t);
        @(negedge hclk);
        check_eq("rst_wr:hreadyout", hreadyout, 1'b1);
        last_rdata = '0;
        @(posedge hclk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        txn_t t;
        hreset = 1'b1;
        repeat (3) @(posedge hclk);
        #1;
        hreset = 1'b0;
        @(negedge hclk);
        check_eq("reset:hreadyout", hreadyout, 1'b1);
        check_eq("reset:hresp", hresp, 1'b0);
        check_eq("reset:hrdata", hrdata, '0);
        check_eq("reset:mem_ce", mem_ce, 1'b0);
        check_eq("reset:mem_we", mem_we, 1'b0);
        check_eq("reset:mem_addr", mem_addr, '0);
        check_eq("reset:mem_wdata", mem_wdata, '0);
        @(posedge hclk); #1;

        txq.push_back(mk(1'b1, 32'h10, {16{8'h11}}));
        run_seq("wr10");
        txq.push_back(mk(1'b0, 32'h10, '0));
        run_seq("rd10");

        txq.push_back(mk(1'b1, 32'h20, rnd_word()));
        txq.push_back(mk(1'b0, 32'h20, '0));
        run_seq("wr_rd_20");

        txq.push_back(mk(1'b0, 32'h40, '0));
        run_seq("rd40");

        txq.push_back(mk(1'b0, 32'h08, '0));
        run_seq("misalign_rd");

        t = mk(1'b0, 32'h40, '0);
        t.size = 4'b0011;
        txq.push_back(t);
        txq.push_back(mk(1'b1, 32'h0010_0040, rnd_word()));
        txq.push_back(mk(1'b1, 32'h44, rnd_word()));
        txq.push_back(mk(1'b0, 32'h40, '0));
        txq.push_back(mk(1'b0, 32'h10, '0));
        txq.push_back(mk(1'b0, 32'h0002_0010, '0));
        run_seq("illegal_mix");

        for (int k = 0; k < 16; k++) txq.push_back(mk(1'b1, 32'h100 + 32'(k) * 16, rnd_word()));
        for (int k = 0; k < 16; k++) txq.push_back(mk(1'b0, 32'h100 + 32'(k) * 16, '0));
        run_seq("burst16");

        reset_during_read();
        txq.push_back(mk(1'b0, 32'h110, '0));
        run_seq("after_rst_rd");

        reset_during_write();
        txq.push_back(mk(1'b0, 32'h200, '0));
        run_seq("after_rst_wr");

        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 40; i++) txq.push_back(rnd_txn());
            run_seq("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
